// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, 32-step restoring divider, data-SRAM request issue.
// Optional divider busy-cycle counter port enabled by defining EXE_DIV_PERF_CNT_EN.
module exe_stage #(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        id_to_exe_valid,
  output logic        exe_allowin,
  input  logic [3:0]  id_op,
  input  logic [1:0]  id_mem_size,
  input  logic        id_mem_unsigned,
  input  logic [31:0] id_src1,
  input  logic [31:0] id_src2,
  input  logic [31:0] id_st_data,
  input  logic        id_gr_we,
  input  logic [4:0]  id_dest,
  input  logic [31:0] id_pc,
  input  logic        mem_allowin,
  output logic        exe_to_mem_valid,
  output logic [31:0] exe_result,
  output logic        exe_load,
  output logic [1:0]  exe_mem_size,
  output logic        exe_mem_unsigned,
  output logic        exe_gr_we,
  output logic [4:0]  exe_dest,
  output logic [31:0] exe_pc,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [31:0] exe_fwd_data,
  output logic        exe_busy
`ifdef EXE_DIV_PERF_CNT_EN
  ,
  output logic [31:0] div_busy_cnt
`endif
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR    = 4'd3,
    OP_XOR  = 4'd4,  OP_SLT  = 4'd5,  OP_SLTU = 4'd6,  OP_SLL   = 4'd7,
    OP_SRL  = 4'd8,  OP_SRA  = 4'd9,  OP_DIV  = 4'd10, OP_DIVU  = 4'd11,
    OP_MOD  = 4'd12, OP_MODU = 4'd13, OP_LOAD = 4'd14, OP_STORE = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  // Latched instruction fields
  logic        valid;
  op_e         op;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] st_data;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] pc;

  // Divider state
  div_state_e       state, state_next;
  logic [CNT_W-1:0] div_cnt;
  logic [31:0]      div_rem;
  logic [31:0]      div_quo;
  logic [31:0]      div_den;
  logic             div_zero;
  logic             q_neg;
  logic             r_neg;
  logic             div_start;
  logic             div_zero_start;
  logic             div_step;

  logic        is_div;
  logic        is_signed_div;
  logic        is_mem;
  logic        ready_go;
  logic        latch;
  logic [31:0] sum;
  logic [31:0] alu_result;
  logic [31:0] abs_src1;
  logic [31:0] abs_src2;
  logic [32:0] rem_shift;
  logic [32:0] rem_diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign is_div        = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_MOD) || (op == OP_MODU);
  assign is_signed_div = (op == OP_DIV) || (op == OP_MOD);
  assign is_mem        = (op == OP_LOAD) || (op == OP_STORE);
  assign ready_go      = is_div ? (state == S_DONE) : 1'b1;
  assign exe_allowin   = ~valid | (ready_go & mem_allowin);
  assign latch         = id_to_exe_valid & exe_allowin & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid        <= 1'b0;
      op           <= OP_ADD;
      mem_size     <= 2'd0;
      mem_unsigned <= 1'b0;
      src1         <= 32'd0;
      src2         <= 32'd0;
      st_data      <= 32'd0;
      gr_we        <= 1'b0;
      dest         <= 5'd0;
      pc           <= 32'd0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (exe_allowin) begin
        valid <= id_to_exe_valid;
      end
      if (latch) begin
        op           <= op_e'(id_op);
        mem_size     <= id_mem_size;
        mem_unsigned <= id_mem_unsigned;
        src1         <= id_src1;
        src2         <= id_src2;
        st_data      <= id_st_data;
        gr_we        <= id_gr_we;
        dest         <= id_dest;
        pc           <= id_pc;
      end
    end
  end

  // Divider control: state register plus next-state/strobe decode
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next     = state;
    div_start      = 1'b0;
    div_zero_start = 1'b0;
    div_step       = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid && is_div && !flush) begin
          if (src2 == 32'd0) begin
            state_next     = S_DONE;
            div_zero_start = 1'b1;
          end else begin
            state_next = S_BUSY;
            div_start  = 1'b1;
          end
        end
      end
      S_BUSY: begin
        div_step = 1'b1;
        if (div_cnt == CNT_LAST) state_next = S_DONE;
      end
      S_DONE: begin
        if (mem_allowin) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (flush) begin
      state_next     = S_IDLE;
      div_step       = 1'b0;
      div_start      = 1'b0;
      div_zero_start = 1'b0;
    end
  end

  assign abs_src1  = (is_signed_div && src1[31]) ? -src1 : src1;
  assign abs_src2  = (is_signed_div && src2[31]) ? -src2 : src2;
  assign rem_shift = {div_rem, div_quo[31]};
  assign rem_diff  = rem_shift - {1'b0, div_den};

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      div_rem  <= 32'd0;
      div_quo  <= 32'd0;
      div_den  <= 32'd0;
      div_zero <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
    end else if (div_start) begin
      div_cnt  <= '0;
      div_rem  <= 32'd0;
      div_quo  <= abs_src1;
      div_den  <= abs_src2;
      div_zero <= 1'b0;
      q_neg    <= is_signed_div & (src1[31] ^ src2[31]);
      r_neg    <= is_signed_div & src1[31];
    end else if (div_zero_start) begin
      div_rem  <= src1;
      div_quo  <= 32'hFFFF_FFFF;
      div_zero <= 1'b1;
    end else if (div_step) begin
      div_cnt <= div_cnt + 1'b1;
      // Restoring step: subtract only when the shifted remainder covers the divisor
      if (!rem_diff[32]) begin
        div_rem <= rem_diff[31:0];
        div_quo <= {div_quo[30:0], 1'b1};
      end else begin
        div_rem <= rem_shift[31:0];
        div_quo <= {div_quo[30:0], 1'b0};
      end
    end
  end

  assign quo_fix = (!div_zero && q_neg) ? -div_quo : div_quo;
  assign rem_fix = (!div_zero && r_neg) ? -div_rem : div_rem;

  assign sum = src1 + src2;

  always_comb begin
    alu_result = sum;
    case (op)
      OP_SUB:  alu_result = src1 - src2;
      OP_AND:  alu_result = src1 & src2;
      OP_OR:   alu_result = src1 | src2;
      OP_XOR:  alu_result = src1 ^ src2;
      OP_SLT:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
      OP_SLTU: alu_result = {31'd0, src1 < src2};
      OP_SLL:  alu_result = src1 << src2[4:0];
      OP_SRL:  alu_result = src1 >> src2[4:0];
      OP_SRA:  alu_result = $unsigned($signed(src1) >>> src2[4:0]);
      OP_DIV,
      OP_DIVU: alu_result = quo_fix;
      OP_MOD,
      OP_MODU: alu_result = rem_fix;
      default: alu_result = sum;
    endcase
  end

  assign exe_result       = alu_result;
  assign exe_to_mem_valid = valid & ready_go & ~flush;
  assign exe_load         = valid & (op == OP_LOAD);
  assign exe_mem_size     = mem_size;
  assign exe_mem_unsigned = mem_unsigned;
  assign exe_gr_we        = valid & gr_we;
  assign exe_dest         = valid ? dest : 5'd0;
  assign exe_pc           = pc;
  assign exe_fwd_data     = (valid & ready_go) ? exe_result : 32'd0;
  assign exe_busy         = valid & ~ready_go;

  // SRAM request fires only in the cycle the instruction actually leaves, so a stall never re-requests
  assign data_sram_en   = valid & ready_go & mem_allowin & is_mem & ~flush;
  assign data_sram_addr = sum;

  always_comb begin
    data_sram_we    = 4'b0000;
    data_sram_wdata = st_data;
    case (mem_size)
      2'd0: data_sram_wdata = {4{st_data[7:0]}};
      2'd1: data_sram_wdata = {2{st_data[15:0]}};
      default: data_sram_wdata = st_data;
    endcase
    if (valid && op == OP_STORE) begin
      case (mem_size)
        2'd0:    data_sram_we = 4'b0001 << sum[1:0];
        2'd1:    data_sram_we = sum[1] ? 4'b1100 : 4'b0011;
        default: data_sram_we = 4'b1111;
      endcase
    end
  end

`ifdef EXE_DIV_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      div_busy_cnt <= 32'd0;
    end else if (state == S_BUSY && div_busy_cnt != 32'hFFFF_FFFF) begin
      div_busy_cnt <= div_busy_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: vector table through a scoreboard, plus stall and flush sequences.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        id_to_exe_valid;
  logic        exe_allowin;
  logic [3:0]  id_op;
  logic [1:0]  id_mem_size;
  logic        id_mem_unsigned;
  logic [31:0] id_src1;
  logic [31:0] id_src2;
  logic [31:0] id_st_data;
  logic        id_gr_we;
  logic [4:0]  id_dest;
  logic [31:0] id_pc;
  logic        mem_allowin;
  logic        exe_to_mem_valid;
  logic [31:0] exe_result;
  logic        exe_load;
  logic [1:0]  exe_mem_size;
  logic        exe_mem_unsigned;
  logic        exe_gr_we;
  logic [4:0]  exe_dest;
  logic [31:0] exe_pc;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] exe_fwd_data;
  logic        exe_busy;
`ifdef EXE_DIV_PERF_CNT_EN
  logic [31:0] div_busy_cnt;
`endif

  exe_stage dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .id_to_exe_valid  (id_to_exe_valid),
    .exe_allowin      (exe_allowin),
    .id_op            (id_op),
    .id_mem_size      (id_mem_size),
    .id_mem_unsigned  (id_mem_unsigned),
    .id_src1          (id_src1),
    .id_src2          (id_src2),
    .id_st_data       (id_st_data),
    .id_gr_we         (id_gr_we),
    .id_dest          (id_dest),
    .id_pc            (id_pc),
    .mem_allowin      (mem_allowin),
    .exe_to_mem_valid (exe_to_mem_valid),
    .exe_result       (exe_result),
    .exe_load         (exe_load),
    .exe_mem_size     (exe_mem_size),
    .exe_mem_unsigned (exe_mem_unsigned),
    .exe_gr_we        (exe_gr_we),
    .exe_dest         (exe_dest),
    .exe_pc           (exe_pc),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .exe_fwd_data     (exe_fwd_data),
    .exe_busy         (exe_busy)
`ifdef EXE_DIV_PERF_CNT_EN
    ,
    .div_busy_cnt     (div_busy_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                         SLT = 4'd5, SLTU = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9,
                         DIV = 4'd10, DIVU = 4'd11, MOD = 4'd12, MODU = 4'd13,
                         LOAD = 4'd14, STORE = 4'd15;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  size;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] sd;
    logic [31:0] res;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          busy;
  } vec_t;

  typedef struct {
    int          idx;
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          busy;
    logic [4:0]  dest;
    logic        gr_we;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] size, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [31:0] sd, input logic [31:0] res,
                              input logic [3:0] we, input logic [31:0] wdata, input int busy);
    vec_t v;
    v.op = op; v.size = size; v.s1 = s1; v.s2 = s2; v.sd = sd;
    v.res = res; v.we = we; v.wdata = wdata; v.busy = busy;
    return v;
  endfunction

  task automatic drive_inputs(input vec_t v, input logic [4:0] dest);
    id_op           = v.op;
    id_mem_size     = v.size;
    id_mem_unsigned = 1'b0;
    id_src1         = v.s1;
    id_src2         = v.s2;
    id_st_data      = v.sd;
    id_gr_we        = (v.op != STORE);
    id_dest         = dest;
    id_pc           = 32'h1C00_0000 + {dest, 2'b00};
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    sb_t e;
    sb_t got;
    int  busy = 0;
    bit  seen = 0;
    @(negedge clk);
    check($sformatf("v%0d allowin before issue", idx), 32'(exe_allowin), 32'd1);
    drive_inputs(v, 5'(idx + 1));
    id_to_exe_valid = 1'b1;
    e.idx = idx; e.op = v.op; e.res = v.res; e.we = v.we; e.wdata = v.wdata;
    e.busy = v.busy; e.dest = 5'(idx + 1); e.gr_we = (v.op != STORE);
    sb.push_back(e);
    @(negedge clk);
    id_to_exe_valid = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (exe_to_mem_valid) begin
        got = sb.pop_front();
        seen = 1;
        check($sformatf("v%0d result", got.idx), exe_result, got.res);
        check($sformatf("v%0d fwd_data", got.idx), exe_fwd_data, got.res);
        check($sformatf("v%0d busy cycles", got.idx), 32'(busy), 32'(got.busy));
        check($sformatf("v%0d dest", got.idx), 32'(exe_dest), 32'(got.dest));
        check($sformatf("v%0d gr_we", got.idx), 32'(exe_gr_we), 32'(got.gr_we));
        check($sformatf("v%0d sram_en", got.idx), 32'(data_sram_en),
              32'(got.op == LOAD || got.op == STORE));
        check($sformatf("v%0d load flag", got.idx), 32'(exe_load), 32'(got.op == LOAD));
        if (got.op == LOAD || got.op == STORE) begin
          check($sformatf("v%0d sram_addr", got.idx), data_sram_addr, got.res);
          check($sformatf("v%0d sram_we", got.idx), 32'(data_sram_we), 32'(got.we));
        end
        if (got.op == STORE)
          check($sformatf("v%0d sram_wdata", got.idx), data_sram_wdata, got.wdata);
        break;
      end
      if (exe_busy) busy++;
      @(negedge clk);
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL v%0d timeout: no exe_to_mem_valid within 60 cycles", idx);
      void'(sb.pop_front());
    end else begin
      @(negedge clk);
      check($sformatf("v%0d sram_en single pulse", idx), 32'(data_sram_en), 32'd0);
      check($sformatf("v%0d valid drops after leave", idx), 32'(exe_to_mem_valid), 32'd0);
    end
  endtask

  initial begin
    int outs;
    logic [31:0] held;
`ifdef EXE_DIV_PERF_CNT_EN
    logic [31:0] cnt0;
`endif

    vecs.push_back(mk(ADD,   2'd2, 32'd5,          32'd7,          32'd0,          32'd12,         4'b0000, 32'd0,          0));
    vecs.push_back(mk(SUB,   2'd2, 32'd5,          32'd7,          32'd0,          32'hFFFF_FFFE,  4'b0000, 32'd0,          0));
    vecs.push_back(mk(AND_,  2'd2, 32'hF0F0_1234,  32'h0FF0_FFFF,  32'd0,          32'h00F0_1234,  4'b0000, 32'd0,          0));
    vecs.push_back(mk(OR_,   2'd2, 32'hF000_0000,  32'h0000_000F,  32'd0,          32'hF000_000F,  4'b0000, 32'd0,          0));
    vecs.push_back(mk(XOR_,  2'd2, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'd0,          32'hF0F0_0F0F,  4'b0000, 32'd0,          0));
    vecs.push_back(mk(SLT,   2'd2, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd1,          4'b0000, 32'd0,          0));
    vecs.push_back(mk(SLTU,  2'd2, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'd0,          4'b0000, 32'd0,          0));
    vecs.push_back(mk(SLL,   2'd2, 32'd1,          32'h0000_0023,  32'd0,          32'd8,          4'b0000, 32'd0,          0));
    vecs.push_back(mk(SRL,   2'd2, 32'h8000_0000,  32'd31,         32'd0,          32'd1,          4'b0000, 32'd0,          0));
    vecs.push_back(mk(SRA,   2'd2, 32'h8000_0000,  32'h0000_0024,  32'd0,          32'hF800_0000,  4'b0000, 32'd0,          0));
    vecs.push_back(mk(DIV,   2'd2, 32'hFFFF_FFF9,  32'd2,          32'd0,          32'hFFFF_FFFD,  4'b0000, 32'd0,          33));
    vecs.push_back(mk(MOD,   2'd2, 32'hFFFF_FFF9,  32'd2,          32'd0,          32'hFFFF_FFFF,  4'b0000, 32'd0,          33));
    vecs.push_back(mk(DIVU,  2'd2, 32'hFFFF_FFF9,  32'd2,          32'd0,          32'h7FFF_FFFC,  4'b0000, 32'd0,          33));
    vecs.push_back(mk(MODU,  2'd2, 32'd100,        32'd7,          32'd0,          32'd2,          4'b0000, 32'd0,          33));
    vecs.push_back(mk(DIV,   2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  4'b0000, 32'd0,          33));
    vecs.push_back(mk(MOD,   2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'd0,          4'b0000, 32'd0,          33));
    vecs.push_back(mk(DIVU,  2'd2, 32'd9,          32'd0,          32'd0,          32'hFFFF_FFFF,  4'b0000, 32'd0,          1));
    vecs.push_back(mk(MODU,  2'd2, 32'd9,          32'd0,          32'd0,          32'd9,          4'b0000, 32'd0,          1));
    vecs.push_back(mk(MOD,   2'd2, 32'hFFFF_FFF9,  32'd0,          32'd0,          32'hFFFF_FFF9,  4'b0000, 32'd0,          1));
    vecs.push_back(mk(DIV,   2'd2, 32'hFFFF_FFF9,  32'd0,          32'd0,          32'hFFFF_FFFF,  4'b0000, 32'd0,          1));
    vecs.push_back(mk(DIV,   2'd2, 32'd7,          32'hFFFF_FFFE,  32'd0,          32'hFFFF_FFFD,  4'b0000, 32'd0,          33));
    vecs.push_back(mk(MOD,   2'd2, 32'd7,          32'hFFFF_FFFE,  32'd0,          32'd1,          4'b0000, 32'd0,          33));
    vecs.push_back(mk(LOAD,  2'd2, 32'hFFFF_FFFC,  32'd8,          32'd0,          32'd4,          4'b0000, 32'd0,          0));
    vecs.push_back(mk(STORE, 2'd0, 32'h0000_1000,  32'd3,          32'h0000_00AB,  32'h0000_1003,  4'b1000, 32'hABAB_ABAB,  0));
    vecs.push_back(mk(STORE, 2'd1, 32'h0000_2000,  32'd2,          32'h1234_5678,  32'h0000_2002,  4'b1100, 32'h5678_5678,  0));
    vecs.push_back(mk(STORE, 2'd1, 32'h0000_2000,  32'd0,          32'h1234_5678,  32'h0000_2000,  4'b0011, 32'h5678_5678,  0));
    vecs.push_back(mk(STORE, 2'd2, 32'h0000_0010,  32'd0,          32'hDEAD_BEEF,  32'h0000_0010,  4'b1111, 32'hDEAD_BEEF,  0));

    reset = 1'b1; flush = 1'b0; id_to_exe_valid = 1'b0; mem_allowin = 1'b1;
    drive_inputs(vecs[0], 5'd0);
    repeat (3) @(negedge clk);
    check("reset allowin", 32'(exe_allowin), 32'd1);
    check("reset to_mem_valid", 32'(exe_to_mem_valid), 32'd0);
    check("reset result", exe_result, 32'd0);
    check("reset sram_en", 32'(data_sram_en), 32'd0);
    check("reset sram_we", 32'(data_sram_we), 32'd0);
    check("reset busy", 32'(exe_busy), 32'd0);
    check("reset fwd", exe_fwd_data, 32'd0);
    check("reset dest", 32'(exe_dest), 32'd0);
    check("reset pc", exe_pc, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Load stalled by mem_allowin=0 for three cycles, then one SRAM pulse
    @(negedge clk);
    mem_allowin = 1'b0;
    drive_inputs(mk(LOAD, 2'd2, 32'h0000_3000, 32'd4, 32'd0, 32'd0, 4'b0, 32'd0, 0), 5'd3);
    id_to_exe_valid = 1'b1;
    @(negedge clk);
    id_to_exe_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d to_mem_valid", k), 32'(exe_to_mem_valid), 32'd1);
      check($sformatf("stall%0d sram_en", k), 32'(data_sram_en), 32'd0);
      check($sformatf("stall%0d result", k), exe_result, 32'h0000_3004);
      check($sformatf("stall%0d allowin", k), 32'(exe_allowin), 32'd0);
      @(negedge clk);
    end
    mem_allowin = 1'b1;
    #1;
    check("stall release sram_en", 32'(data_sram_en), 32'd1);
    check("stall release addr", data_sram_addr, 32'h0000_3004);
    @(negedge clk);
    check("stall pulse ends", 32'(data_sram_en), 32'd0);
    check("stall valid drops", 32'(exe_to_mem_valid), 32'd0);

    // Flush while a load is ready to leave
    drive_inputs(mk(LOAD, 2'd2, 32'h0000_4000, 32'd0, 32'd0, 32'd0, 4'b0, 32'd0, 0), 5'd4);
    id_to_exe_valid = 1'b1;
    @(negedge clk);
    id_to_exe_valid = 1'b0;
    flush = 1'b1;
    #1;
    check("flush gates to_mem_valid", 32'(exe_to_mem_valid), 32'd0);
    check("flush gates sram_en", 32'(data_sram_en), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    check("flush load allowin", 32'(exe_allowin), 32'd1);
    check("flush load gr_we", 32'(exe_gr_we), 32'd0);

    // Flush at BUSY cycle 10 of a divide
    drive_inputs(mk(DIV, 2'd2, 32'd1000, 32'd3, 32'd0, 32'd0, 4'b0, 32'd0, 0), 5'd5);
    id_to_exe_valid = 1'b1;
    @(negedge clk);
    id_to_exe_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("div busy before flush", 32'(exe_busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("div flush allowin", 32'(exe_allowin), 32'd1);
    check("div flush busy", 32'(exe_busy), 32'd0);
    outs = 0;
    for (int k = 0; k < 40; k++) begin
      if (exe_to_mem_valid) outs++;
      @(negedge clk);
    end
    check("div flush no output", 32'(outs), 32'd0);

    // Flush overrides a simultaneous latch
    drive_inputs(vecs[0], 5'd6);
    id_to_exe_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    id_to_exe_valid = 1'b0;
    flush = 1'b0;
    check("flush-vs-latch to_mem_valid", 32'(exe_to_mem_valid), 32'd0);
    check("flush-vs-latch dest", 32'(exe_dest), 32'd0);

`ifdef EXE_DIV_PERF_CNT_EN
    cnt0 = div_busy_cnt;
    run_vec(vecs[13], 100);
    check("perf cnt delta", div_busy_cnt - cnt0, 32'd32);
`endif

    // Pipeline recovers after flushes
    run_vec(vecs[10], 200);
    held = 32'(sb.size());
    check("scoreboard drained", held, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
